mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, fixed-latency memory between the instruction-fetch stage and the MEM-stage data path of the pipelined MIPS core. Each access runs as a req/ack transaction: grant, issue, wait for the data to return, then acknowledge. The block exports a pipeline `stall` while any request is outstanding. Data accesses win over fetches, with alternation so fetch cannot starve.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; must be >= 1.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word; registered; holds between fetches.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` is valid in this cycle.
- `d_req`  in  1  data request; held with its payload until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load (driven from memctrl bit 1).
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; registered; updated only on load acks.
- `d_ack`  out  1  one-cycle pulse marking completion.
- `mem_en`  out  1  memory access strobe; registered; high for exactly 1 cycle per access.
- `mem_we`  out  1  write enable; qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  memory address; registered.
- `mem_wdata`  out  DATA_W  memory write data; registered.
- `mem_rdata`  in  DATA_W  memory read data.
- `stall`  out  1  combinational: `(if_req & ~if_ack) | (d_req & ~d_ack)`.

## Operation
- State machine: IDLE, WAIT, ACK.
- **IDLE**, no request: stay in IDLE, `mem_en` = 0.
- **IDLE**, request present: select a winner, latch its payload into the `mem_*` registers, set `mem_en` = 1, load `cnt` = `MEM_LAT`, go to WAIT.
- **Winner selection:**
  - Data wins if only `d_req` is present, or both are present and `last_grant` = FETCH.
  - Otherwise fetch wins.
  - `last_grant` updates on every grant.
- **WAIT:**
  - `mem_en` and `mem_we` clear after the first WAIT cycle.
  - `cnt` decrements each cycle.
  - When `cnt` = 1: capture `mem_rdata` into the winner's rdata register (data stores do not capture), assert the winner's ack, go to ACK.
- **ACK:** the ack is high this cycle. Go to IDLE unconditionally; no new grant is made here, because the requester's req is still high.
- **Requester protocol:** drop req in the cycle after ack. If req drops early, the access still completes and ack still pulses; the payload is latched at grant.
- **Counter width:** `cnt` is `$clog2(MEM_LAT+1)` bits. It never underflows, since it is reloaded only in IDLE.
- **Reset (asserted, including mid-access):**
  - State goes to IDLE and `last_grant` to FETCH.
  - All outputs go to 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata`, `if_ack`, `d_ack`.
  - Any in-flight memory response is discarded and no ack is issued.

## Timing
- Request sampled at the end of cycle 0:
  - `mem_en` high in cycle 1.
  - `mem_rdata` valid in cycle 1+`MEM_LAT`.
  - Ack and rdata valid in cycle 2+`MEM_LAT`.
  - IDLE in cycle 3+`MEM_LAT`.
- Earliest next `mem_en` is cycle 4+`MEM_LAT`. Throughput is one access per `MEM_LAT`+3 cycles.
- Request-to-ack latency is `MEM_LAT`+2 cycles; with `MEM_LAT` = 2, ack lands in cycle 4.
- `stall` is high from the first cycle a req is present through the cycle before its ack. It drops in the ack cycle (combinational).
- A losing requester keeps waiting. It is granted in the IDLE cycle after the winner's ACK, so its `mem_en` comes `MEM_LAT`+3 cycles after the winner's.

## Test plan
- **Reset:** assert `reset_n` = 0 asynchronously mid-cycle -> all outputs 0 immediately; `stall` reflects the reqs only.
- **Single fetch (`MEM_LAT` = 2):** `if_req` = 1, `if_addr` = 0x400 in cycle 0, memory returns 0x8C010004 -> `mem_en` = 1 with `mem_addr` = 0x400 in cycle 1 only; `if_ack` in cycle 4 with `if_rdata` = 0x8C010004; `stall` high in cycles 0-3.
- **Simultaneous requests from reset:** `if_req` (0x404) and `d_req` load (0x10 -> 0x12345678) -> data is granted first (`mem_addr` 0x10 in cycle 1, `d_ack` in cycle 4); fetch `mem_en` in cycle 6 with `mem_addr` 0x404.
- **Alternation:** data re-requests immediately after its ack while fetch is pending -> fetch is granted before the second data access.
- **Store:** `d_we` = 1, `d_addr` = 0x20, `d_wdata` = 0xDEADBEEF -> `mem_en` = `mem_we` = 1 with that address and data for 1 cycle; `d_ack` in cycle 4; `d_rdata` unchanged from its previous value.
- **Reset mid-WAIT:** assert reset during cycle 2 of a fetch -> no `if_ack`. After release with no req: no `mem_en`. A new req then completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the two pipeline requesters and the shared memory.
// master: the arbiter's view; slave: the requester/memory environment's view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data access.
// Data wins ties unless it won the previous grant, so fetch cannot starve.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input logic          clk,
    input logic          reset_n,
    mem_arbiter_if.master bus
);
    localparam int unsigned CntW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;
    typedef enum logic {GrantFetch, GrantData} grant_e;

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            winner_q, winner_d;
    logic              store_q, store_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              data_wins;

    assign data_wins = bus.d_req & (~bus.if_req | (last_grant_q == GrantFetch));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        store_d      = store_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.d_req) begin
                    cnt_d    = CntW'(MEM_LAT);
                    mem_en_d = 1'b1;
                    state_d  = StWait;
                    if (data_wins) begin
                        winner_d     = GrantData;
                        last_grant_d = GrantData;
                        store_d      = bus.d_we;
                        mem_we_d     = bus.d_we;
                        mem_addr_d   = bus.d_addr;
                        mem_wdata_d  = bus.d_wdata;
                    end else begin
                        winner_d     = GrantFetch;
                        last_grant_d = GrantFetch;
                        store_d      = 1'b0;
                        mem_addr_d   = bus.if_addr;
                    end
                end
            end
            StWait: begin
                // The strobe cycle itself is not counted, so cnt hits 1 exactly in the
                // cycle mem_rdata is valid (MEM_LAT cycles after the strobe).
                if (!mem_en_q) begin
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StAck;
                        if (winner_q == GrantData) begin
                            d_ack_d = 1'b1;
                            if (!store_q) begin
                                d_rdata_d = bus.mem_rdata;
                            end
                        end else begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            StAck: begin
                // Requester still holds req this cycle, so never grant from here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= GrantFetch;
            winner_q     <= GrantFetch;
            store_q      <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            store_q      <= store_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-built
// sequences for arbitration, alternation and reset in the middle of an access.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MEM_LAT = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0400: return 32'h8C01_0004;
            32'h0000_0010: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    // Memory: read data is valid only in the single cycle MEM_LAT after the strobe.
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    logic [MEM_LAT-1:0] rv_pipe;
    always @(posedge clk) begin
        rv_pipe[0] <= bus.mem_en & ~bus.mem_we;
        rd_pipe[0] <= mem_model(bus.mem_addr);
        for (int i = 1; i < MEM_LAT; i++) begin
            rv_pipe[i] <= rv_pipe[i-1];
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign bus.mem_rdata = rv_pipe[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } txn_t;

    // One isolated transaction; entered and left just after a rising edge with reqs low.
    task automatic run_txn(input txn_t t);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                bus.if_req  = ~t.is_data;
                bus.if_addr = t.addr;
                bus.d_req   = t.is_data;
                bus.d_we    = t.we;
                bus.d_addr  = t.addr;
                bus.d_wdata = t.wdata;
            end else if (c == 5) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
            @(negedge clk);
            check("txn mem_en", bus.mem_en, c == 1);
            if (c == 1) begin
                check("txn mem_addr", bus.mem_addr, t.addr);
                check("txn mem_we", bus.mem_we, t.is_data & t.we);
                if (t.is_data && t.we) check("txn mem_wdata", bus.mem_wdata, t.wdata);
            end
            check("txn if_ack", bus.if_ack, !t.is_data && c == 4);
            check("txn d_ack", bus.d_ack, t.is_data && c == 4);
            check("txn stall", bus.stall, c < 4);
            if (c == 4) begin
                if (t.is_data) check("txn d_rdata", bus.d_rdata, t.exp_rd);
                else           check("txn if_rdata", bus.if_rdata, t.exp_rd);
            end
            @(posedge clk);
            #1;
        end
    endtask

    txn_t vecs [6];

    initial begin
        logic e_en, e_iack, e_dack, e_stall;
        logic [31:0] e_addr;

        vecs[0] = '{is_data: 1'b0, we: 1'b0, addr: 32'h400, wdata: 32'h0, exp_rd: 32'h8C01_0004};
        vecs[1] = '{is_data: 1'b1, we: 1'b1, addr: 32'h20,  wdata: 32'hDEAD_BEEF,
                    exp_rd: 32'hA5A5_5A4E};
        vecs[2] = '{is_data: 1'b1, we: 1'b0, addr: 32'h30,  wdata: 32'h0, exp_rd: 32'hA5A5_5A6A};
        vecs[3] = '{is_data: 1'b0, we: 1'b0, addr: 32'h408, wdata: 32'h0, exp_rd: 32'hA5A5_5E52};
        vecs[4] = '{is_data: 1'b1, we: 1'b1, addr: 32'h24,  wdata: 32'hCAFE_F00D,
                    exp_rd: 32'hA5A5_5A6A};
        vecs[5] = '{is_data: 1'b1, we: 1'b0, addr: 32'h10,  wdata: 32'h0, exp_rd: 32'h1234_5678};

        reset_n     = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst mem_en", bus.mem_en, 0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst if_ack", bus.if_ack, 0);
        check("rst d_ack", bus.d_ack, 0);
        check("rst stall idle", bus.stall, 0);
        bus.d_req = 1'b1;
        #1;
        check("rst stall req", bus.stall, 1);
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Both request together: data first, fetch next, then data's re-request.
        for (int c = 0; c < 16; c++) begin
            bus.if_req  = (c <= 9);
            bus.if_addr = 32'h404;
            bus.d_req   = (c <= 14);
            bus.d_we    = 1'b0;
            bus.d_addr  = (c <= 4) ? 32'h10 : 32'h14;
            e_en    = (c == 1) || (c == 6) || (c == 11);
            e_addr  = (c == 1) ? 32'h10 : (c == 6) ? 32'h404 : 32'h14;
            e_iack  = (c == 9);
            e_dack  = (c == 4) || (c == 14);
            e_stall = (bus.if_req & ~e_iack) | (bus.d_req & ~e_dack);
            @(negedge clk);
            check("arb mem_en", bus.mem_en, e_en);
            if (e_en) check("arb mem_addr", bus.mem_addr, e_addr);
            check("arb if_ack", bus.if_ack, e_iack);
            check("arb d_ack", bus.d_ack, e_dack);
            check("arb stall", bus.stall, e_stall);
            if (c == 4)  check("arb d_rdata 1", bus.d_rdata, 32'h1234_5678);
            if (c == 9)  check("arb if_rdata", bus.if_rdata, 32'hA5A5_5E5E);
            if (c == 14) check("arb d_rdata 2", bus.d_rdata, 32'hA5A5_5A4E);
            @(posedge clk);
            #1;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Reset in the middle of a fetch's WAIT phase.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid mem_en", bus.mem_en, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid rst mem_en", bus.mem_en, 0);
        check("mid rst mem_addr", bus.mem_addr, 0);
        check("mid rst mem_wdata", bus.mem_wdata, 0);
        check("mid rst if_rdata", bus.if_rdata, 0);
        check("mid rst d_rdata", bus.d_rdata, 0);
        check("mid rst stall", bus.stall, 1);
        bus.if_req = 1'b0;
        #1;
        check("mid rst stall drop", bus.stall, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post rst mem_en", bus.mem_en, 0);
            check("post rst if_ack", bus.if_ack, 0);
            check("post rst d_ack", bus.d_ack, 0);
            @(posedge clk);
            #1;
        end
        run_txn(vecs[0]);
        run_txn(vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
